// File: rtl/cordic_tanh_sched.sv
// cordic_tanh_sched: round-robin scheduler that shares one pipelined CORDIC tanh core among NUM_REQ requesters.
// Define CORDIC_SCHED_STATS_EN to add the stat_inflight / stat_issued counters.
module cordic_tanh_sched #(
    parameter int NUM_REQ = 4,
    parameter int WORD_SZ = 18,
    parameter int FRAC_SZ = 16,
    parameter int LATENCY = 36
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WORD_SZ-1:0] req_angle,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [WORD_SZ-1:0]         rsp_data,
    output logic [WORD_SZ-1:0]         core_angle,
    input  logic [WORD_SZ-1:0]         core_out,
    input  logic                       cfg_hold,
    output logic                       drained
`ifdef CORDIC_SCHED_STATS_EN
    ,
    output logic [$clog2(LATENCY+1)-1:0] stat_inflight,
    output logic [31:0]                  stat_issued
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(LATENCY + 1);

    // Angles are plain Q(WORD_SZ-FRAC_SZ).FRAC_SZ words; only the split itself must be sane.
    if (FRAC_SZ >= WORD_SZ) begin : g_bad_frac
        $error("cordic_tanh_sched: FRAC_SZ must be smaller than WORD_SZ");
    end

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_found;
    logic               issue;
    logic [LATENCY-1:0] tag_v;
    logic [IDX_W-1:0]   tag_idx [LATENCY];
    logic               tag_exit;
    logic               pend_v;
    logic [IDX_W-1:0]   pend_idx;
    logic [CNT_W-1:0]   inflight;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!gnt_found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    // Handshake: a requester holds req_valid with a stable angle until it sees
    // req_ready; a transfer happens on a clock edge where both are high.
    assign issue      = gnt_found && (state_q == ST_RUN);
    assign req_ready  = issue ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign core_angle = issue ? req_angle[gnt_idx*WORD_SZ +: WORD_SZ] : '0;
    assign tag_exit   = tag_v[LATENCY-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (issue) begin
            rr_ptr <= IDX_W'((int'(gnt_idx) + 1) % NUM_REQ);
        end
    end

    // Tag line tracks the core pipeline; the extra pending stage lines the
    // exiting tag up with the cycle in which core_out carries its result.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v  <= '0;
            pend_v <= 1'b0;
        end else begin
            tag_v[0] <= issue;
            for (int k = 1; k < LATENCY; k++) begin
                tag_v[k] <= tag_v[k-1];
            end
            pend_v <= tag_exit;
        end
    end

    always_ff @(posedge clk) begin
        tag_idx[0] <= gnt_idx;
        for (int k = 1; k < LATENCY; k++) begin
            tag_idx[k] <= tag_idx[k-1];
        end
        pend_idx <= tag_idx[LATENCY-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= pend_v ? (NUM_REQ'(1) << pend_idx) : '0;
            if (pend_v) begin
                rsp_data <= core_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else if (issue && !tag_exit) begin
            inflight <= inflight + CNT_W'(1);
        end else if (!issue && tag_exit) begin
            inflight <= inflight - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // A grant made in the same cycle cfg_hold rises still issues; hold bites next cycle.
    always_comb begin
        state_d = state_q;
        drained = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (cfg_hold) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!cfg_hold) begin
                    state_d = ST_RUN;
                end else if ((inflight == '0) && !pend_v) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                drained = 1'b1;
                if (!cfg_hold) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

`ifdef CORDIC_SCHED_STATS_EN
    logic [31:0] issued_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            issued_q <= '0;
        end else if (issue) begin
            issued_q <= issued_q + 32'd1;
        end
    end

    assign stat_inflight = inflight;
    assign stat_issued   = issued_q;
`endif

endmodule

// File: tb/tb_cordic_tanh_sched.sv
// tb_cordic_tanh_sched: directed bench for cordic_tanh_sched with an ideal tanh core model
// and a scoreboard that checks every response's cycle, requester and value.
module tb_cordic_tanh_sched;

    localparam int NUM_REQ = 4;
    localparam int WORD_SZ = 18;
    localparam int LATENCY = 36;
    localparam int W       = 64;
    localparam int PD      = 32;

    logic                       clk;
    logic                       rst;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*WORD_SZ-1:0] req_angle;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ-1:0]         rsp_valid;
    logic [WORD_SZ-1:0]         rsp_data;
    logic [WORD_SZ-1:0]         core_angle;
    logic [WORD_SZ-1:0]         core_out;
    logic                       cfg_hold;
    logic                       drained;
`ifdef CORDIC_SCHED_STATS_EN
    logic [$clog2(LATENCY+1)-1:0] stat_inflight;
    logic [31:0]                  stat_issued;
`endif

    cordic_tanh_sched #(
        .NUM_REQ(NUM_REQ), .WORD_SZ(WORD_SZ), .FRAC_SZ(16), .LATENCY(LATENCY)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_angle(req_angle), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .core_angle(core_angle), .core_out(core_out),
        .cfg_hold(cfg_hold), .drained(drained)
`ifdef CORDIC_SCHED_STATS_EN
        , .stat_inflight(stat_inflight), .stat_issued(stat_issued)
`endif
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- ideal core: result appears on core_out LATENCY edges after sampling
    function automatic logic [WORD_SZ-1:0] tanh_q(input logic [WORD_SZ-1:0] a);
        real x, e, t;
        int  v;
        x = $itor($signed(a)) / 65536.0;
        e = $exp(2.0 * x);
        t = (e - 1.0) / (e + 1.0) * 65536.0;
        if (t >= 0.0) v = $rtoi(t + 0.5);
        else          v = -$rtoi(-t + 0.5);
        return WORD_SZ'(v);
    endfunction

    logic [WORD_SZ-1:0] core_pipe [0:LATENCY];
    always @(posedge clk) begin
        core_pipe[0] <= tanh_q(core_angle);
        for (int k = 1; k <= LATENCY; k++) core_pipe[k] <= core_pipe[k-1];
    end
    assign core_out = core_pipe[LATENCY];

    // ---------------- bench state ----------------
    int                 n_checks;
    int                 n_fail;
    int                 cyc;
    int                 rsp_seen;
    int                 last_rsp_cyc;
    logic [W-1:0]       exp_q[$];
    int                 gnt_log[$];
    int                 gnt_cyc[$];
    logic [NUM_REQ-1:0] granted;
    logic [WORD_SZ-1:0] p_ang [NUM_REQ][PD];
    logic [WORD_SZ-1:0] p_exp [NUM_REQ][PD];
    int                 p_head [NUM_REQ];
    int                 p_tail [NUM_REQ];
    logic [WORD_SZ-1:0] t_ang [5];
    logic [WORD_SZ-1:0] t_exp [5];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", tag, obs, obs, exp, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_req(input int i, input logic [WORD_SZ-1:0] ang, input logic [WORD_SZ-1:0] ex);
        p_ang[i][p_tail[i] % PD] = ang;
        p_exp[i][p_tail[i] % PD] = ex;
        p_tail[i]++;
    endtask

    function automatic bit any_pending();
        for (int i = 0; i < NUM_REQ; i++) if (p_head[i] != p_tail[i]) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: check responses, advance the request queues, then sample grants before the next edge.
    task automatic step();
        logic [W-1:0] e;
        logic         legal;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (rsp_valid != '0) begin
            rsp_seen++;
            last_rsp_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("rsp_spurious", 32'(rsp_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_cycle", 32'(cyc), e[63:32]);
                check("rsp_onehot", 32'(rsp_valid), 32'd1 << e[31:24]);
                check("rsp_data", 32'(rsp_data), 32'(e[17:0]));
            end
        end else if (exp_q.size() != 0 && int'(exp_q[0][63:32]) < cyc) begin
            e = exp_q.pop_front();
            check("rsp_missing_due", 32'(cyc), e[63:32]);
        end
        for (int i = 0; i < NUM_REQ; i++) if (granted[i]) p_head[i]++;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i] = (p_head[i] != p_tail[i]);
            req_angle[i*WORD_SZ +: WORD_SZ] = req_valid[i] ? p_ang[i][p_head[i] % PD] : '0;
        end
        #1;
        legal = $onehot0(req_ready) && ((req_ready & ~req_valid) == '0);
        check("ready_legal", 32'(legal), 32'd1);
        granted = req_ready & req_valid;
        if (granted == '0) check("core_bubble", 32'(core_angle), 32'd0);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (granted[i]) begin
                check("core_angle", 32'(core_angle), 32'(p_ang[i][p_head[i] % PD]));
                gnt_log.push_back(i);
                gnt_cyc.push_back(cyc);
                exp_q.push_back({32'(cyc + LATENCY + 2), 8'(i), 6'd0, p_exp[i][p_head[i] % PD]});
            end
        end
    endtask

    task automatic run_idle(input int max_cyc);
        int n;
        n = 0;
        while ((any_pending() || exp_q.size() != 0 || granted != '0) && n < max_cyc) begin
            step();
            n++;
        end
        check("idle_reached", 32'(n < max_cyc), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        step();
        rst = 1'b0;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int g0, r0, n, rel_cyc, drain_cyc;
        n_checks = 0; n_fail = 0; cyc = 0; rsp_seen = 0; last_rsp_cyc = 0;
        granted = '0; rst = 1'b1; cfg_hold = 1'b0; req_valid = '0; req_angle = '0;
        for (int i = 0; i < NUM_REQ; i++) begin p_head[i] = 0; p_tail[i] = 0; end
        t_ang[0] = 18'h08000; t_exp[0] = 18'd30285;
        t_ang[1] = 18'h10000; t_exp[1] = 18'd49912;
        t_ang[2] = 18'h30000; t_exp[2] = 18'h33D08;
        t_ang[3] = 18'h38000; t_exp[3] = 18'h389B3;
        t_ang[4] = 18'h04000; t_exp[4] = 18'd16051;

        repeat (3) step();
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_drained", 32'(drained), 32'd0);
        check("rst_core_angle", 32'(core_angle), 32'd0);
`ifdef CORDIC_SCHED_STATS_EN
        check("rst_stat_inflight", 32'(stat_inflight), 32'd0);
        check("rst_stat_issued", stat_issued, 32'd0);
`endif
        rst = 1'b0;

        // 1: single issue from requester 0
        g0 = gnt_log.size(); r0 = rsp_seen;
        push_req(0, 18'h08000, 18'd30285);
        run_idle(80);
        check("t1_grant_idx", 32'(gnt_log[g0]), 32'd0);
        check("t1_rsp_count", 32'(rsp_seen - r0), 32'd1);
        check("t1_rsp_data_held", 32'(rsp_data), 32'd30285);

        // 2: all four valid, first grant lands in the cycle after reset release
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NUM_REQ; i++) push_req(i, t_ang[(i + k) % 5], t_exp[(i + k) % 5]);
        g0 = gnt_log.size(); r0 = rsp_seen;
        do_reset();
        rel_cyc = cyc;
        run_idle(120);
        check("t2_first_after_rst", 32'(gnt_cyc[g0]), 32'(rel_cyc));
        for (int k = 0; k < 8; k++) check("t2_rr_order", 32'(gnt_log[g0 + k]), 32'(k % 4));
        check("t2_back_to_back", 32'(gnt_cyc[g0 + 7] - gnt_cyc[g0]), 32'd7);
        check("t2_rsp_count", 32'(rsp_seen - r0), 32'd8);

        // 3: rr_ptr=1 with only 3 and 0 valid, then rr_ptr must be back at 1
        push_req(0, t_ang[4], t_exp[4]);
        run_idle(80);
        g0 = gnt_log.size();
        push_req(3, t_ang[1], t_exp[1]);
        push_req(0, t_ang[3], t_exp[3]);
        run_idle(80);
        check("t3_skip_first", 32'(gnt_log[g0]), 32'd3);
        check("t3_skip_second", 32'(gnt_log[g0 + 1]), 32'd0);
        g0 = gnt_log.size();
        for (int i = 0; i < NUM_REQ; i++) push_req(i, t_ang[i], t_exp[i]);
        run_idle(80);
        check("t3_ptr_at_1", 32'(gnt_log[g0]), 32'd1);
        check("t3_then_0", 32'(gnt_log[g0 + 3]), 32'd0);

        // 4: ten issues, hold, drain, resume
        g0 = gnt_log.size(); r0 = rsp_seen;
        for (int k = 0; k < 10; k++) push_req(k % 4, t_ang[k % 5], t_exp[k % 5]);
        n = 0;
        while (gnt_log.size() - g0 < 10 && n < 60) begin step(); n++; end
        check("t4_ten_granted", 32'(gnt_log.size() - g0), 32'd10);
        cfg_hold = 1'b1;
        push_req(1, t_ang[0], t_exp[0]);
        step();
        check("t4_ready_off", 32'(req_ready), 32'd0);
        check("t4_not_drained_yet", 32'(drained), 32'd0);
        n = 0;
        while (!drained && n < 100) begin step(); n++; end
        drain_cyc = cyc;
        check("t4_drained", 32'(drained), 32'd1);
        check("t4_no_rsp_left", 32'(exp_q.size()), 32'd0);
        check("t4_rsp_count", 32'(rsp_seen - r0), 32'd10);
        check("t4_drain_after_rsp", 32'(drain_cyc > last_rsp_cyc), 32'd1);
        repeat (3) step();
        check("t4_halt_ready_off", 32'(req_ready), 32'd0);
        check("t4_halt_no_grant", 32'(gnt_log.size() - g0), 32'd10);
        cfg_hold = 1'b0;
        step();
        check("t4_resume_grant", 32'(gnt_log.size() - g0), 32'd11);
        check("t4_resume_idx", 32'(gnt_log[gnt_log.size() - 1]), 32'd1);
        check("t4_resume_undrained", 32'(drained), 32'd0);
        run_idle(80);

        // 5: reset five cycles after an issue discards its result
        g0 = gnt_log.size();
        push_req(2, 18'h10000, 18'd49912);
        n = 0;
        while (gnt_log.size() == g0 && n < 10) begin step(); n++; end
        check("t5_granted", 32'(gnt_log.size() - g0), 32'd1);
        repeat (5) step();
`ifdef CORDIC_SCHED_STATS_EN
        check("t5_stat_inflight_pre", 32'(stat_inflight), 32'd1);
        check("t5_stat_issued_pre", stat_issued, 32'd27);
`endif
        r0 = rsp_seen;
        do_reset();
`ifdef CORDIC_SCHED_STATS_EN
        check("t5_stat_inflight", 32'(stat_inflight), 32'd0);
        check("t5_stat_issued", stat_issued, 32'd0);
`endif
        repeat (50) step();
        check("t5_no_rsp", 32'(rsp_seen - r0), 32'd0);
        check("t5_drained", 32'(drained), 32'd0);

        // 6: negative angles
        r0 = rsp_seen;
        push_req(1, 18'h30000, 18'h33D08);
        push_req(2, 18'h38000, 18'h389B3);
        run_idle(80);
        check("t6_rsp_count", 32'(rsp_seen - r0), 32'd2);
        check("t6_hold_data", 32'(rsp_data), 32'h389B3);
        repeat (3) step();
        check("t6_data_still_held", 32'(rsp_data), 32'h389B3);

        check("final_exp_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
